// File: rtl/fread_stream_source_if.sv
// Byte-stream bus of fread_stream_source: loader request handshake,
// payload output stream and the SPI byte receiver input.
// master = the stream source itself, slave = the environment around it.
interface fread_stream_source_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;

  modport master (
    input  req_valid, rx_data, rx_valid, rx_first,
    output req_ready, resp_data, resp_valid
  );

  modport slave (
    output req_valid, rx_data, rx_valid, rx_first,
    input  req_ready, resp_data, resp_valid
  );
endinterface

// File: rtl/fread_stream_source.sv
// fread_stream_source: accepts a one-shot load request, raises the ESP IRQ,
// collects the ESP's fread frame bytes in a small FIFO and replays exactly
// XFER_LEN payload bytes on an unthrottled, gap-limited output stream.
// Optional build macro FREAD_CHECKSUM_EN: expect a mod-256 sum trailer byte
// after the payload and flag a mismatch on csum_err.
module fread_stream_source #(
  parameter int         XFER_LEN   = 1024,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] CMD_FREAD  = 8'hF8,
  parameter int         OUT_GAP    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fread_stream_source_if.master bus,
  output logic                  esp_irq_n,
  output logic                  busy,
  output logic                  overflow,
  output logic                  csum_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(XFER_LEN + 1);
  localparam logic [3:0]    GAP_RELOAD = 4'(OUT_GAP - 1);
  localparam logic [BW-1:0] LEN_FULL   = BW'(XFER_LEN);
  localparam logic [BW-1:0] LEN_LAST   = BW'(XFER_LEN - 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ACK, HDR, STREAM, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [7:0]    resp_data_q, resp_data_d;
  logic          esp_irq_n_q, esp_irq_n_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]    gap_q, gap_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic push, pop, take;
  logic rx_hdr, rx_payload;

`ifdef FREAD_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       csum_err_q, csum_err_d;
  assign csum_err = csum_err_q;
`else
  assign csum_err = 1'b0;
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign esp_irq_n      = esp_irq_n_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;

  assign rx_hdr     = bus.rx_valid & bus.rx_first;
  assign rx_payload = bus.rx_valid & ~bus.rx_first;

  // Next-state logic: FSM, payload intake, FIFO bookkeeping and paced output
  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    esp_irq_n_d  = esp_irq_n_q;
    overflow_d   = overflow_q;
    byte_cnt_d   = byte_cnt_q;
    gap_d        = gap_q;
    push         = 1'b0;
    take         = 1'b0;
`ifdef FREAD_CHECKSUM_EN
    sum_d        = sum_q;
    csum_err_d   = csum_err_q;
`endif

    // Output side runs in every state; the gap counter paces the pulses.
    pop = (count_q != '0) && (gap_q == 4'd0);
    if (pop) begin
      resp_valid_d = 1'b1;
      resp_data_d  = fifo_mem[rd_ptr_q];
      gap_d        = GAP_RELOAD;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d     = ACK;
          req_ready_d = 1'b1;
        end
      end
      ACK: begin
        byte_cnt_d  = '0;
        gap_d       = 4'd0;
        esp_irq_n_d = 1'b0;
        state_d     = HDR;
`ifdef FREAD_CHECKSUM_EN
        sum_d       = 8'd0;
`endif
      end
      HDR: begin
        if (rx_hdr && (bus.rx_data == CMD_FREAD)) state_d = STREAM;
      end
      STREAM: begin
        // Continuation frame header: CMD_FREAD is dropped silently, anything else is a framing loss.
        if (rx_hdr && (bus.rx_data != CMD_FREAD)) overflow_d = 1'b1;
`ifdef FREAD_CHECKSUM_EN
        take = rx_payload && (byte_cnt_q != LEN_FULL);
        if (take) sum_d = sum_q + bus.rx_data;
        if (rx_payload && (byte_cnt_q == LEN_FULL)) begin
          // Trailer byte: compared, never stored.
          if (bus.rx_data != sum_q) csum_err_d = 1'b1;
          esp_irq_n_d = 1'b1;
          state_d     = DRAIN;
        end
`else
        take = rx_payload;
        if (take && (byte_cnt_q == LEN_LAST)) begin
          esp_irq_n_d = 1'b1;
          state_d     = DRAIN;
        end
`endif
        if (take) begin
          // Dropped bytes still count so the transfer always terminates.
          if (count_q == FIFO_FULL) overflow_d = 1'b1;
          else                      push       = 1'b1;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (count_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State and registered outputs; reset aborts any transfer in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'd0;
      esp_irq_n_q  <= 1'b1;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      byte_cnt_q   <= '0;
      gap_q        <= 4'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef FREAD_CHECKSUM_EN
      sum_q        <= 8'd0;
      csum_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      esp_irq_n_q  <= esp_irq_n_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_q        <= gap_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef FREAD_CHECKSUM_EN
      sum_q        <= sum_d;
      csum_err_q   <= csum_err_d;
`endif
    end
  end

  // FIFO storage write port; contents need no reset since pointers gate validity
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr_q] <= bus.rx_data;
  end

endmodule

// File: tb/tb_fread_stream_source.sv
// Directed bench for fread_stream_source. Instance A (OUT_GAP=1) carries the
// functional transfers with a byte scoreboard; instance B (OUT_GAP=15) shares
// the rx stream and is used for the overflow case. Honours FREAD_CHECKSUM_EN.
module tb_fread_stream_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst;
  logic       req_a, req_b;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first;
  logic       irq_a, busy_a, ovf_a, cs_a;
  logic       irq_b, busy_b, ovf_b, cs_b;

  fread_stream_source_if ia ();
  fread_stream_source_if ib ();

  assign ia.req_valid = req_a;
  assign ib.req_valid = req_b;
  assign ia.rx_data   = rx_data;
  assign ib.rx_data   = rx_data;
  assign ia.rx_valid  = rx_valid;
  assign ib.rx_valid  = rx_valid;
  assign ia.rx_first  = rx_first;
  assign ib.rx_first  = rx_first;

  fread_stream_source #(.OUT_GAP(1)) u_dut_a (
    .clk(clk), .rst(srst), .bus(ia),
    .esp_irq_n(irq_a), .busy(busy_a), .overflow(ovf_a), .csum_err(cs_a)
  );

  fread_stream_source #(.OUT_GAP(15)) u_dut_b (
    .clk(clk), .rst(srst), .bus(ib),
    .esp_irq_n(irq_b), .busy(busy_b), .overflow(ovf_b), .csum_err(cs_b)
  );

  int         total = 0;
  int         bad   = 0;
  int         cnt_a = 0;
  int         cnt_b = 0;
  logic [7:0] tb_sum = 8'd0;
  logic [7:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then check A's output stream against the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    if (ia.resp_valid === 1'b1) begin
      cnt_a++;
      chk("a_resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("a_resp_data", 32'(ia.resp_data), 32'(sb.pop_front()));
    end
    if (ib.resp_valid === 1'b1) cnt_b++;
  endtask

  task automatic send_byte(input logic first, input logic [7:0] d, input int gap);
    rx_valid = 1'b1;
    rx_first = first;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
    rx_first = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic send_payload(input int n, input int base, input int gap, input bit to_sb);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = 8'((base + i) & 255);
      if (to_sb) sb.push_back(d);
      tb_sum = tb_sum + d;
      send_byte(1'b0, d, gap);
    end
  endtask

  task automatic send_trailer();
`ifdef FREAD_CHECKSUM_EN
    send_byte(1'b0, tb_sum, 1);
`endif
  endtask

  task automatic request(input bit use_b);
    if (use_b) req_b = 1'b1; else req_a = 1'b1;
    step();
    req_a = 1'b0;
    req_b = 1'b0;
    step();
  endtask

  task automatic wait_idle(input bit use_b, input int budget, input string tag);
    int n;
    n = 0;
    while (((use_b ? busy_b : busy_a) !== 1'b0) && (n < budget)) begin
      step();
      n++;
    end
    chk(tag, 32'(use_b ? busy_b : busy_a), 32'd0);
  endtask

  task automatic chk_reset_a(input string pfx);
    chk({pfx, "_req_ready"},  32'(ia.req_ready),  32'd0);
    chk({pfx, "_resp_valid"}, 32'(ia.resp_valid), 32'd0);
    chk({pfx, "_resp_data"},  32'(ia.resp_data),  32'd0);
    chk({pfx, "_irq_n"},      32'(irq_a),         32'd1);
    chk({pfx, "_busy"},       32'(busy_a),        32'd0);
    chk({pfx, "_overflow"},   32'(ovf_a),         32'd0);
    chk({pfx, "_csum_err"},   32'(cs_a),          32'd0);
  endtask

  initial begin
    srst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    rx_data = 8'd0; rx_valid = 1'b0; rx_first = 1'b0;
    repeat (3) step();
    chk_reset_a("rst");
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    chk("rst_b_irq_n", 32'(irq_b), 32'd1);
    srst = 1'b0;
    repeat (2) step();

    // Handshake: req_ready one cycle after the request, IRQ the cycle after that
    req_a = 1'b1;
    chk("hs_ready_idle", 32'(ia.req_ready), 32'd0);
    step();
    req_a = 1'b0;
    chk("hs_ready_ack", 32'(ia.req_ready), 32'd1);
    chk("hs_busy_ack", 32'(busy_a), 32'd1);
    chk("hs_irq_ack", 32'(irq_a), 32'd1);
    step();
    chk("hs_ready_hdr", 32'(ia.req_ready), 32'd0);
    chk("hs_irq_hdr", 32'(irq_a), 32'd0);
    chk("hs_busy_hdr", 32'(busy_a), 32'd1);
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    chk("hs_req_ignored", 32'(ia.req_ready), 32'd0);

    // Full transfer, one byte every 4 cycles
    cnt_a = 0; tb_sum = 8'd0;
    send_byte(1'b1, 8'hF8, 4);
    send_payload(1023, 0, 4, 1'b1);
    chk("full_irq_before_last", 32'(irq_a), 32'd0);
    send_payload(1, 1023, 4, 1'b1);
`ifdef FREAD_CHECKSUM_EN
    chk("full_irq_pre_trailer", 32'(irq_a), 32'd0);
    send_trailer();
`endif
    chk("full_irq_done", 32'(irq_a), 32'd1);
    wait_idle(1'b0, 200, "full_idle");
    chk("full_count", 32'(cnt_a), 32'd1024);
    chk("full_sb_left", 32'(sb.size()), 32'd0);
    chk("full_overflow", 32'(ovf_a), 32'd0);
    chk("full_data_hold", 32'(ia.resp_data), 32'hFF);
    $display("xfer full: outputs=%0d", cnt_a);

    // Bad header and stray bytes in HDR, then two 512-byte frames
    cnt_a = 0; tb_sum = 8'd0;
    request(1'b0);
    send_byte(1'b1, 8'h55, 4);
    for (int i = 0; i < 6; i++) send_byte(1'b0, 8'(i), 2);
    send_byte(1'b0, 8'hF8, 2);
    chk("chunk_hdr_no_output", 32'(cnt_a), 32'd0);
    chk("chunk_hdr_busy", 32'(busy_a), 32'd1);
    send_byte(1'b1, 8'hF8, 4);
    send_payload(512, 0, 4, 1'b1);
    send_byte(1'b1, 8'hF8, 4);
    send_payload(512, 512, 4, 1'b1);
    send_trailer();
    chk("chunk_irq_done", 32'(irq_a), 32'd1);
    wait_idle(1'b0, 200, "chunk_idle");
    chk("chunk_count", 32'(cnt_a), 32'd1024);
    chk("chunk_sb_left", 32'(sb.size()), 32'd0);
    chk("chunk_overflow", 32'(ovf_a), 32'd0);
    $display("xfer chunked: outputs=%0d", cnt_a);

    // Overflow on the slow instance: bytes every cycle, one output per 15 cycles
    cnt_a = 0; cnt_b = 0; tb_sum = 8'd0;
    request(1'b1);
    send_byte(1'b1, 8'hF8, 1);
    send_payload(1024, 0, 1, 1'b0);
    send_trailer();
    chk("ovf_irq_done", 32'(irq_b), 32'd1);
    wait_idle(1'b1, 400, "ovf_idle");
    chk("ovf_flag", 32'(ovf_b), 32'd1);
    chk("ovf_outputs_dropped", 32'((cnt_b >= 16) && (cnt_b < 1024)), 32'd1);
    chk("ovf_csum_err", 32'(cs_b), 32'd0);
    chk("ovf_a_idle_ignores_rx", 32'(cnt_a), 32'd0);
    chk("ovf_a_overflow", 32'(ovf_a), 32'd0);
    $display("xfer overflow: outputs=%0d", cnt_b);

    // Reset in the middle of STREAM, then a fresh transfer
    cnt_a = 0; tb_sum = 8'd0;
    request(1'b0);
    send_byte(1'b1, 8'hF8, 4);
    send_payload(300, 0, 4, 1'b1);
    chk("mid_sb_drained", 32'(sb.size()), 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd1);
    srst = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h77;
    step();
    rx_valid = 1'b0;
    srst = 1'b0;
    chk_reset_a("mid_rst");
    $display("xfer aborted: outputs=%0d", cnt_a);
    step();
    cnt_a = 0; tb_sum = 8'd0;
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    chk("fresh_ready_ack", 32'(ia.req_ready), 32'd1);
    step();
    send_byte(1'b1, 8'hF8, 4);
    send_payload(1024, 0, 4, 1'b1);
    send_trailer();
    wait_idle(1'b0, 200, "fresh_idle");
    chk("fresh_count", 32'(cnt_a), 32'd1024);
    chk("fresh_sb_left", 32'(sb.size()), 32'd0);
    $display("xfer fresh: outputs=%0d", cnt_a);

`ifdef FREAD_CHECKSUM_EN
    // 1024 x 0x01 sums to 0x00 mod 256
    for (int pass = 0; pass < 2; pass++) begin
      cnt_a = 0;
      request(1'b0);
      send_byte(1'b1, 8'hF8, 4);
      for (int i = 0; i < 1024; i++) begin
        sb.push_back(8'h01);
        send_byte(1'b0, 8'h01, 4);
      end
      chk("cs_irq_pre_trailer", 32'(irq_a), 32'd0);
      send_byte(1'b0, (pass == 0) ? 8'h00 : 8'h01, 1);
      chk("cs_irq_after_trailer", 32'(irq_a), 32'd1);
      chk("cs_err", 32'(cs_a), (pass == 0) ? 32'd0 : 32'd1);
      wait_idle(1'b0, 200, "cs_idle");
      chk("cs_count", 32'(cnt_a), 32'd1024);
      $display("xfer checksum pass %0d: outputs=%0d csum_err=%0b", pass, cnt_a, cs_a);
    end
`else
    chk("no_cs_err", 32'(cs_a), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
